// File: rtl/iob_cache_repl_engine.sv
// iob_cache_repl_engine: per-set victim-way selector for an N-way cache.
// Replacement state lives in a 2^NLINES_W-entry register array with a lookup
// port and an update port; a same-line update is forwarded into the lookup.
// Invalid ways are chosen first, then the policy victim (LRU counters,
// PLRU MRU bits, PLRU tree or 16-bit LFSR random).
// Optional feature macro: IOB_CACHE_REPL_LOCK_EN (enables lock_mask_i and
// all_locked_o; when undefined the lock mask is ignored).
module iob_cache_repl_engine #(
  parameter int N_WAYS     = 8,
  parameter int NLINES_W   = 7,
  parameter int NWAYS_W    = $clog2(N_WAYS),
  parameter int REP_POLICY = 2
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic                init_i,
  output logic                busy_o,
  input  logic                req_valid_i,
  input  logic [NLINES_W-1:0] req_line_i,
  input  logic [N_WAYS-1:0]   req_valid_ways_i,
  input  logic [N_WAYS-1:0]   lock_mask_i,
  output logic                rsp_valid_o,
  output logic [N_WAYS-1:0]   way_select_o,
  output logic [NWAYS_W-1:0]  way_select_bin_o,
  output logic                all_locked_o,
  input  logic                upd_en_i,
  input  logic [NLINES_W-1:0] upd_line_i,
  input  logic [N_WAYS-1:0]   upd_way_hit_i
);

  localparam int LINES   = 2 ** NLINES_W;
  // Widest policy (LRU counters) sizes every entry; narrower policies leave upper bits at 0.
  localparam int STATE_W = N_WAYS * NWAYS_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [NWAYS_W-1:0] way_t;
  typedef logic [N_WAYS-1:0]  mask_t;
  typedef enum logic {SWEEP, IDLE} fsm_t;

  function automatic state_t policy_reset();
    state_t s;
    s = '0;
    if (REP_POLICY == 0) begin
      for (int i = 0; i < N_WAYS; i++) s[i*NWAYS_W +: NWAYS_W] = way_t'(i);
    end
    return s;
  endfunction

  function automatic way_t policy_victim(input state_t s, input logic [15:0] lfsr);
    way_t              v;
    logic              found;
    mask_t             t;
    logic [NWAYS_W:0]  node;
    v     = '0;
    found = 1'b0;
    t     = {s[N_WAYS-2:0], 1'b0};  // tree node k lives at t[k], k = 1..N_WAYS-1
    node  = {{NWAYS_W{1'b0}}, 1'b1};
    case (REP_POLICY)
      0: begin
        for (int i = 0; i < N_WAYS; i++)
          if (s[i*NWAYS_W +: NWAYS_W] == '0) v = way_t'(i);
      end
      1: begin
        for (int i = 0; i < N_WAYS; i++)
          if (!found && !s[i]) begin
            v     = way_t'(i);
            found = 1'b1;
          end
      end
      2: begin
        for (int l = 0; l < NWAYS_W; l++)
          node = {node[NWAYS_W-1:0], t[node[NWAYS_W-1:0]]};
        v = node[NWAYS_W-1:0];  // leaf heap index minus N_WAYS
      end
      default: v = lfsr[NWAYS_W-1:0];
    endcase
    return v;
  endfunction

  function automatic state_t policy_update(input state_t s, input mask_t hit);
    state_t           n;
    way_t             old;
    way_t             ww;
    mask_t            t;
    mask_t            m;
    logic [NWAYS_W:0] node;
    n    = s;
    old  = '0;
    ww   = '0;
    for (int i = 0; i < N_WAYS; i++)
      if (hit[i]) begin
        old = s[i*NWAYS_W +: NWAYS_W];
        ww  = way_t'(i);
      end
    t    = {s[N_WAYS-2:0], 1'b0};
    m    = s[N_WAYS-1:0] | hit;
    node = {{NWAYS_W{1'b0}}, 1'b1};
    if (hit != '0) begin
      case (REP_POLICY)
        0: begin
          for (int i = 0; i < N_WAYS; i++) begin
            if (hit[i]) n[i*NWAYS_W +: NWAYS_W] = way_t'(N_WAYS - 1);
            else if (s[i*NWAYS_W +: NWAYS_W] > old)
              n[i*NWAYS_W +: NWAYS_W] = s[i*NWAYS_W +: NWAYS_W] - 1'b1;
          end
        end
        1: begin
          if (&m) m = hit;
          n[N_WAYS-1:0] = m;
        end
        2: begin
          // Walk the hit path MSB-first, pointing each node away from the hit way.
          for (int l = 0; l < NWAYS_W; l++) begin
            t[node[NWAYS_W-1:0]] = ~ww[NWAYS_W-1];
            node = {node[NWAYS_W-1:0], ww[NWAYS_W-1]};
            ww   = ww << 1;
          end
          n[N_WAYS-2:0] = t[N_WAYS-1:1];
        end
        default: n = s;
      endcase
    end
    return n;
  endfunction

  // Returns {all_locked, way}.
  function automatic logic [NWAYS_W:0] pick_way(input mask_t valid, input mask_t lock,
                                                input way_t pv);
    mask_t cand;
    mask_t unl;
    way_t  b;
    logic  al;
    cand = ~valid & ~lock;
    unl  = ~lock;
    b    = pv;
    al   = 1'b0;
    if (|cand) begin
      for (int i = N_WAYS - 1; i >= 0; i--) if (cand[i]) b = way_t'(i);
    end else if (!lock[pv]) begin
      b = pv;
    end else if (|unl) begin
      for (int i = N_WAYS - 1; i >= 0; i--) if (unl[i]) b = way_t'(i);
    end else begin
      al = 1'b1;
    end
    return {al, b};
  endfunction

  fsm_t                state_q, state_d;
  logic [NLINES_W-1:0] cnt_q, cnt_d;
  logic [15:0]         lfsr_q;
  state_t              mem_q [LINES];
  logic                rsp_valid_q;
  mask_t               sel_q;
  way_t                bin_q;
  logic                al_q;

  mask_t               lock_eff;
  logic                busy, req_acc, upd_acc;
  state_t              upd_new, eff_state;
  way_t                pv;
  logic [NWAYS_W:0]    pick;

`ifdef IOB_CACHE_REPL_LOCK_EN
  assign lock_eff = lock_mask_i;
`else
  assign lock_eff = '0;
  logic unused_lock;
  assign unused_lock = ^lock_mask_i;
`endif

  assign busy      = (state_q == SWEEP);
  assign req_acc   = req_valid_i && !busy;
  assign upd_acc   = upd_en_i && !busy;
  assign upd_new   = policy_update(mem_q[upd_line_i], upd_way_hit_i);
  assign eff_state = (upd_acc && (upd_line_i == req_line_i)) ? upd_new : mem_q[req_line_i];
  assign pv        = policy_victim(eff_state, lfsr_q);
  assign pick      = pick_way(req_valid_ways_i, lock_eff, pv);

  // Sweep/idle state register and line counter.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep one line per cycle, init_i restarts from line 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = IDLE;
    end
    if (init_i) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end
  end

  // Free-running LFSR, x^16+x^14+x^13+x^11.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // State array: sweep writes reset state, otherwise record accepted accesses.
  always_ff @(posedge clk_i) begin
    if (busy)         mem_q[cnt_q]      <= policy_reset();
    else if (upd_acc) mem_q[upd_line_i] <= upd_new;
  end

  // Registered response; outputs hold until the next accepted request.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      sel_q       <= mask_t'(1);
      bin_q       <= '0;
      al_q        <= 1'b0;
    end else begin
      rsp_valid_q <= req_acc;
      if (req_acc) begin
        bin_q <= pick[NWAYS_W-1:0];
        sel_q <= mask_t'(1) << pick[NWAYS_W-1:0];
        al_q  <= pick[NWAYS_W];
      end
    end
  end

  assign busy_o           = busy;
  assign rsp_valid_o      = rsp_valid_q;
  assign way_select_o     = sel_q;
  assign way_select_bin_o = bin_q;
  assign all_locked_o     = al_q;

endmodule

// File: tb/tb_iob_cache_repl_engine.sv
// Bench for iob_cache_repl_engine: four instances (PLRU tree N=8, LRU N=4,
// PLRU MRU N=4, RANDOM N=8), all with 8 lines, sharing clock, reset and
// stimulus buses; per-instance request/update enables select the target.
module tb_iob_cache_repl_engine;

`ifdef IOB_CACHE_REPL_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [3:0] req_v = '0, upd_v = '0;
  logic [2:0] req_line = '0, upd_line = '0;
  logic [7:0] vways = 8'hFF, lockm = '0, hit = '0;

  logic       busy_t, busy_l, busy_m, busy_r;
  logic       rsp_t, rsp_l, rsp_m, rsp_r;
  logic [7:0] sel_t, sel_r;
  logic [3:0] sel_l, sel_m;
  logic [2:0] bin_t, bin_r;
  logic [1:0] bin_l, bin_m;
  logic       al_t, al_l, al_m, al_r;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  // Reference LFSR for the RANDOM instance.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  iob_cache_repl_engine #(.N_WAYS(8), .NLINES_W(3), .REP_POLICY(2)) u_tree (
    .clk_i(clk), .reset(reset), .init_i(init), .busy_o(busy_t),
    .req_valid_i(req_v[0]), .req_line_i(req_line), .req_valid_ways_i(vways),
    .lock_mask_i(lockm), .rsp_valid_o(rsp_t), .way_select_o(sel_t),
    .way_select_bin_o(bin_t), .all_locked_o(al_t), .upd_en_i(upd_v[0]),
    .upd_line_i(upd_line), .upd_way_hit_i(hit));

  iob_cache_repl_engine #(.N_WAYS(4), .NLINES_W(3), .REP_POLICY(0)) u_lru (
    .clk_i(clk), .reset(reset), .init_i(init), .busy_o(busy_l),
    .req_valid_i(req_v[1]), .req_line_i(req_line), .req_valid_ways_i(vways[3:0]),
    .lock_mask_i(lockm[3:0]), .rsp_valid_o(rsp_l), .way_select_o(sel_l),
    .way_select_bin_o(bin_l), .all_locked_o(al_l), .upd_en_i(upd_v[1]),
    .upd_line_i(upd_line), .upd_way_hit_i(hit[3:0]));

  iob_cache_repl_engine #(.N_WAYS(4), .NLINES_W(3), .REP_POLICY(1)) u_mru (
    .clk_i(clk), .reset(reset), .init_i(init), .busy_o(busy_m),
    .req_valid_i(req_v[2]), .req_line_i(req_line), .req_valid_ways_i(vways[3:0]),
    .lock_mask_i(lockm[3:0]), .rsp_valid_o(rsp_m), .way_select_o(sel_m),
    .way_select_bin_o(bin_m), .all_locked_o(al_m), .upd_en_i(upd_v[2]),
    .upd_line_i(upd_line), .upd_way_hit_i(hit[3:0]));

  iob_cache_repl_engine #(.N_WAYS(8), .NLINES_W(3), .REP_POLICY(3)) u_rand (
    .clk_i(clk), .reset(reset), .init_i(init), .busy_o(busy_r),
    .req_valid_i(req_v[3]), .req_line_i(req_line), .req_valid_ways_i(vways),
    .lock_mask_i(lockm), .rsp_valid_o(rsp_r), .way_select_o(sel_r),
    .way_select_bin_o(bin_r), .all_locked_o(al_r), .upd_en_i(upd_v[3]),
    .upd_line_i(upd_line), .upd_way_hit_i(hit));

  function automatic int get_busy(int d);
    case (d) 0: return int'(busy_t); 1: return int'(busy_l);
             2: return int'(busy_m); default: return int'(busy_r); endcase
  endfunction
  function automatic int get_rsp(int d);
    case (d) 0: return int'(rsp_t); 1: return int'(rsp_l);
             2: return int'(rsp_m); default: return int'(rsp_r); endcase
  endfunction
  function automatic int get_sel(int d);
    case (d) 0: return int'(sel_t); 1: return int'(sel_l);
             2: return int'(sel_m); default: return int'(sel_r); endcase
  endfunction
  function automatic int get_bin(int d);
    case (d) 0: return int'(bin_t); 1: return int'(bin_l);
             2: return int'(bin_m); default: return int'(bin_r); endcase
  endfunction
  function automatic int get_al(int d);
    case (d) 0: return int'(al_t); 1: return int'(al_l);
             2: return int'(al_m); default: return int'(al_r); endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         dut;
    bit         upd;
    bit         req;
    logic [2:0] line;
    logic [7:0] hit;
    logic [7:0] valid;
    logic [7:0] lock;
    int         exp_bin;
    bit         exp_al;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int d, bit u, bit r, logic [2:0] ln, logic [7:0] h,
                              logic [7:0] vl, logic [7:0] lk, int eb, bit ea);
    vec_t v;
    v.dut = d; v.upd = u; v.req = r; v.line = ln; v.hit = h;
    v.valid = vl; v.lock = lk; v.exp_bin = eb; v.exp_al = ea;
    vecs.push_back(v);
  endfunction

  // Called at a negedge; drives one cycle, returns at the following negedge.
  task automatic apply_vec(input vec_t v, input string tag);
    req_line = v.line; upd_line = v.line; hit = v.hit;
    vways = v.valid; lockm = v.lock;
    req_v[v.dut] = v.req; upd_v[v.dut] = v.upd;
    @(negedge clk);
    req_v = '0; upd_v = '0;
    if (v.req) begin
      chk({tag, "_rsp"}, get_rsp(v.dut), 1);
      chk({tag, "_bin"}, get_bin(v.dut), v.exp_bin);
      chk({tag, "_sel"}, get_sel(v.dut), 1 << v.exp_bin);
      chk({tag, "_all_locked"}, get_al(v.dut), int'(v.exp_al));
    end
  endtask

  initial begin
    int n;
    bit saw_rsp;
    int e0, e1, e2;
    vec_t v;

    // Reset values.
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_busy_%0d", d), get_busy(d), 1);
      chk($sformatf("reset_rsp_%0d", d), get_rsp(d), 0);
      chk($sformatf("reset_sel_%0d", d), get_sel(d), 1);
      chk($sformatf("reset_bin_%0d", d), get_bin(d), 0);
      chk($sformatf("reset_al_%0d", d), get_al(d), 0);
    end

    // Release reset; count busy cycles while firing requests/updates that must be dropped.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    saw_rsp = 1'b0;
    while (get_busy(0) != 0 && n < 50) begin
      n++;
      req_v = 4'hF; upd_v = 4'hF; req_line = 3'd0; upd_line = 3'd0;
      hit = 8'h01; vways = 8'hFF;
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (get_rsp(d) != 0) saw_rsp = 1'b1;
    end
    req_v = '0; upd_v = '0; hit = '0;
    chk("sweep_busy_cycles", n, 8);
    chk("sweep_rsp_seen", int'(saw_rsp), 0);
    for (int d = 1; d < 4; d++) chk($sformatf("sweep_done_busy_%0d", d), get_busy(d), 0);

    // Directed vectors.
    // PLRU tree: line 0 untouched by the dropped update.
    add(0, 0, 1, 3'd0, 8'h00, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 0, 3'd5, 8'h01, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 1, 3'd5, 8'h00, 8'hFF, 8'h00, 4, 0);
    add(0, 1, 0, 3'd5, 8'h10, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 1, 3'd5, 8'h00, 8'hFF, 8'h00, 2, 0);
    // Same-cycle forwarding on line 3.
    add(0, 1, 1, 3'd3, 8'h01, 8'hFF, 8'h00, 4, 0);
    add(0, 1, 1, 3'd3, 8'h01, 8'hFB, 8'h00, 2, 0);
    add(0, 0, 1, 3'd6, 8'h00, 8'h7F, 8'h00, 7, 0);
    // Locking on a reset-state line (tree victim 0).
    add(0, 0, 1, 3'd7, 8'h00, 8'hFF, 8'hFF, 0, LOCK);
    add(0, 0, 1, 3'd7, 8'h00, 8'hFF, 8'h0F, LOCK ? 4 : 0, 0);
    add(0, 0, 1, 3'd7, 8'h00, 8'hFE, 8'h01, LOCK ? 1 : 0, 0);
    // LRU N=4.
    add(1, 0, 1, 3'd0, 8'h00, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 0, 3'd2, 8'h01, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 0, 3'd2, 8'h02, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 0, 3'd2, 8'h04, 8'hFF, 8'h00, 0, 0);
    add(1, 0, 1, 3'd2, 8'h00, 8'hFF, 8'h00, 3, 0);
    add(1, 1, 0, 3'd2, 8'h08, 8'hFF, 8'h00, 0, 0);
    add(1, 0, 1, 3'd2, 8'h00, 8'hFF, 8'h00, 0, 0);
    add(1, 0, 1, 3'd3, 8'h00, 8'hFD, 8'h00, 1, 0);
    // PLRU MRU N=4.
    add(2, 0, 1, 3'd0, 8'h00, 8'hFF, 8'h00, 0, 0);
    add(2, 1, 0, 3'd1, 8'h01, 8'hFF, 8'h00, 0, 0);
    add(2, 1, 0, 3'd1, 8'h02, 8'hFF, 8'h00, 0, 0);
    add(2, 1, 0, 3'd1, 8'h04, 8'hFF, 8'h00, 0, 0);
    add(2, 1, 0, 3'd1, 8'h08, 8'hFF, 8'h00, 0, 0);
    add(2, 0, 1, 3'd1, 8'h00, 8'hFF, 8'h00, 0, 0);
    add(2, 1, 0, 3'd1, 8'h01, 8'hFF, 8'h00, 0, 0);
    add(2, 0, 1, 3'd1, 8'h00, 8'hFF, 8'h00, 1, 0);
    add(2, 1, 1, 3'd1, 8'h00, 8'hFF, 8'h00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    lockm = '0;
    vways = 8'hFF;

    // RANDOM: back-to-back requests, pulse width and output hold.
    e0 = int'(m_lfsr[2:0]);
    req_v[3] = 1'b1;
    @(negedge clk);
    chk("rand0_rsp", get_rsp(3), 1);
    chk("rand0_bin", get_bin(3), e0);
    e1 = int'(m_lfsr[2:0]);
    @(negedge clk);
    chk("rand1_rsp", get_rsp(3), 1);
    chk("rand1_bin", get_bin(3), e1);
    e2 = int'(m_lfsr[2:0]);
    @(negedge clk);
    req_v = '0;
    chk("rand2_bin", get_bin(3), e2);
    chk("rand2_sel", get_sel(3), 1 << e2);
    chk("rand2_al", get_al(3), 0);
    @(negedge clk);
    chk("rand_rsp_pulse", get_rsp(3), 0);
    chk("rand_hold_bin", get_bin(3), e2);

    // init_i, then a second init_i mid-sweep restarts the count.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_busy", get_busy(0), 1);
    repeat (3) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    n = 0;
    while (get_busy(0) != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("init_restart_busy_cycles", n, 8);
    v = '{dut: 0, upd: 1'b0, req: 1'b1, line: 3'd5, hit: 8'h00, valid: 8'hFF,
          lock: 8'h00, exp_bin: 0, exp_al: 1'b0};
    apply_vec(v, "init_tree_line5");
    v = '{dut: 2, upd: 1'b0, req: 1'b1, line: 3'd1, hit: 8'h00, valid: 8'hFF,
          lock: 8'h00, exp_bin: 0, exp_al: 1'b0};
    apply_vec(v, "init_mru_line1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
